// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: boot hold, trap/branch/jump arbitration, pending redirect capture and wrong-path shadow.
// Optional REDIRECT_STATS_EN adds per-kind applied-redirect counters.
module fetch_redirect_ctrl #(
   parameter int WIDTH         = 32,
   parameter int BOOT_CYCLES   = 4,
   parameter int SHADOW_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jmp_valid,
   input  logic [WIDTH-1:0] jmp_target,
   input  logic             trap_req,
   input  logic [WIDTH-1:0] trap_vec,
   input  logic             load_use,
   input  logic             imem_ready,
   output logic             pc_en,
   output logic [1:0]       pc_sel,
   output logic [WIDTH-1:0] target,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             trap_ack
`ifdef REDIRECT_STATS_EN
   ,
   output logic [31:0]      stat_trap,
   output logic [31:0]      stat_branch,
   output logic [31:0]      stat_jump
`endif
);

   localparam logic [1:0] ST_BOOT   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_SHADOW = 2'd2;

   localparam logic [1:0] KIND_JMP  = 2'd1;
   localparam logic [1:0] KIND_BR   = 2'd2;
   localparam logic [1:0] KIND_TRAP = 2'd3;

   localparam int SW = (SHADOW_CYCLES > 1) ? $clog2(SHADOW_CYCLES + 1) : 1;
   localparam logic [3:0]    BOOT_LAST   = 4'(BOOT_CYCLES - 1);
   localparam logic [SW-1:0] SHADOW_LOAD = SW'(SHADOW_CYCLES);

   logic [1:0]       r_state;
   logic [3:0]       r_bootCnt;
   logic [SW-1:0]    r_shadowCnt;
   logic             r_pendValid;
   logic [1:0]       r_pendKind;
   logic [WIDTH-1:0] r_pendAddr;

   logic             w_active;
   logic             w_sel;
   logic             w_selNew;
   logic [1:0]       w_selKind;
   logic [WIDTH-1:0] w_selAddr;
   logic             w_apply;
   logic             w_capture;

   assign w_active = (r_state != ST_BOOT);

   // A held trap outranks a fresh branch; a held redirect outranks a fresh jump.
   always_comb begin
      w_sel     = 1'b0;
      w_selNew  = 1'b0;
      w_selKind = KIND_JMP;
      w_selAddr = '0;
      if (w_active) begin
         if (trap_req) begin
            w_sel     = 1'b1;
            w_selNew  = 1'b1;
            w_selKind = KIND_TRAP;
            w_selAddr = trap_vec;
         end else if (br_taken && !(r_pendValid && (r_pendKind == KIND_TRAP))) begin
            w_sel     = 1'b1;
            w_selNew  = 1'b1;
            w_selKind = KIND_BR;
            w_selAddr = br_target;
         end else if (r_pendValid) begin
            w_sel     = 1'b1;
            w_selKind = r_pendKind;
            w_selAddr = r_pendAddr;
         end else if (jmp_valid && (r_state == ST_RUN)) begin
            w_sel     = 1'b1;
            w_selNew  = 1'b1;
            w_selKind = KIND_JMP;
            w_selAddr = jmp_target;
         end
      end
   end

   assign w_apply   = w_sel & imem_ready;
   assign w_capture = w_sel & ~imem_ready & w_selNew;

   always_comb begin
      pc_en       = 1'b0;
      pc_sel      = 2'b00;
      target      = '0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      trap_ack    = 1'b0;
      if (w_apply) begin
         pc_en       = 1'b1;
         pc_sel      = 2'b10;
         target      = w_selAddr;
         flush_if_id = 1'b1;
         flush_id_ex = (w_selKind != KIND_JMP);
         trap_ack    = (w_selKind == KIND_TRAP);
      end else if (w_capture) begin
         flush_if_id = 1'b1;
         flush_id_ex = (w_selKind != KIND_JMP);
      end else if (w_sel) begin
         flush_id_ex = load_use;
      end else if (w_active) begin
         pc_en       = imem_ready & ~load_use;
         flush_id_ex = load_use;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_BOOT;
         r_bootCnt   <= '0;
         r_shadowCnt <= '0;
         r_pendValid <= 1'b0;
         r_pendKind  <= KIND_JMP;
         r_pendAddr  <= '0;
      end else if (r_state == ST_BOOT) begin
         if (r_bootCnt == BOOT_LAST) begin
            r_state <= ST_RUN;
         end else begin
            r_bootCnt <= r_bootCnt + 4'd1;
         end
      end else if (w_apply) begin
         r_pendValid <= 1'b0;
         r_shadowCnt <= SHADOW_LOAD;
         r_state     <= (SHADOW_CYCLES == 0) ? ST_RUN : ST_SHADOW;
      end else begin
         if (w_capture) begin
            r_pendValid <= 1'b1;
            r_pendKind  <= w_selKind;
            r_pendAddr  <= w_selAddr;
         end
         // The shadow window keeps counting down while a redirect waits for imem.
         if (r_state == ST_SHADOW) begin
            if (r_shadowCnt <= SW'(1)) begin
               r_shadowCnt <= '0;
               r_state     <= ST_RUN;
            end else begin
               r_shadowCnt <= r_shadowCnt - SW'(1);
            end
         end
      end
   end

`ifdef REDIRECT_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_trap   <= '0;
         stat_branch <= '0;
         stat_jump   <= '0;
      end else if (w_apply) begin
         if (w_selKind == KIND_TRAP) stat_trap   <= stat_trap + 32'd1;
         if (w_selKind == KIND_BR)   stat_branch <= stat_branch + 32'd1;
         if (w_selKind == KIND_JMP)  stat_jump   <= stat_jump + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios with literal pins, then randomized traffic
// compared every cycle against a rank-based behavioural model.
module tb_fetch_redirect_ctrl;

   localparam int WIDTH         = 32;
   localparam int BOOT_CYCLES   = 4;
   localparam int SHADOW_CYCLES = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             br_taken, jmp_valid, trap_req, load_use, imem_ready;
   logic [WIDTH-1:0] br_target, jmp_target, trap_vec;
   logic             pc_en, flush_if_id, flush_id_ex, trap_ack;
   logic [1:0]       pc_sel;
   logic [WIDTH-1:0] target;

   fetch_redirect_ctrl #(
      .WIDTH(WIDTH), .BOOT_CYCLES(BOOT_CYCLES), .SHADOW_CYCLES(SHADOW_CYCLES)
   ) dut (
      .clk(clk), .rst(rst),
      .br_taken(br_taken), .br_target(br_target),
      .jmp_valid(jmp_valid), .jmp_target(jmp_target),
      .trap_req(trap_req), .trap_vec(trap_vec),
      .load_use(load_use), .imem_ready(imem_ready),
      .pc_en(pc_en), .pc_sel(pc_sel), .target(target),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .trap_ack(trap_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: boot cycles left, shadow cycles left, held redirect with rank 3=trap 2=branch 1=jump.
   int          mBootLeft, mShadowLeft, mPendRank;
   bit          mPendValid;
   logic [31:0] mPendAddr;
   int          eSelRank;
   logic [31:0] eSelAddr;
   bit          eApply, eCapture;
   logic        ePcEn, eFlushIf, eFlushEx, eTrapAck;
   logic [1:0]  ePcSel;
   logic [31:0] eTarget;
   bit          trapHeld;
   logic [31:0] trapVecHeld;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic pin(input string name, input logic [31:0] dutVal, input logic [31:0] modelVal,
                      input logic [31:0] lit);
      chk({name, "_dut"}, dutVal, lit);
      chk({name, "_model"}, modelVal, lit);
   endtask

   task automatic modelReset();
      mBootLeft   = BOOT_CYCLES;
      mShadowLeft = 0;
      mPendValid  = 1'b0;
      mPendRank   = 0;
      mPendAddr   = '0;
      trapHeld    = 1'b0;
   endtask

   task automatic applyStimulus(input bit tr, input logic [31:0] tv, input bit br, input logic [31:0] bt,
                                input bit jv, input logic [31:0] jt, input bit lu, input bit rdy);
      trap_req   = tr;
      trap_vec   = tv;
      br_taken   = br;
      br_target  = bt;
      jmp_valid  = jv;
      jmp_target = jt;
      load_use   = lu;
      imem_ready = rdy;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic computeExpected();
      int          newRank;
      logic [31:0] newAddr;
      bit          takeNew;
      ePcEn = 0; ePcSel = 2'b00; eTarget = '0; eFlushIf = 0; eFlushEx = 0; eTrapAck = 0;
      eApply = 0; eCapture = 0; eSelRank = 0; eSelAddr = '0;
      if (mBootLeft == 0) begin
         newRank = 0;
         newAddr = '0;
         if (trap_req) begin newRank = 3; newAddr = trap_vec; end
         else if (br_taken) begin newRank = 2; newAddr = br_target; end
         else if (jmp_valid && mShadowLeft == 0) begin newRank = 1; newAddr = jmp_target; end
         takeNew = (newRank > 0) &&
                   (!mPendValid || newRank > mPendRank || (newRank == mPendRank && newRank >= 2));
         if (takeNew) begin eSelRank = newRank; eSelAddr = newAddr; end
         else if (mPendValid) begin eSelRank = mPendRank; eSelAddr = mPendAddr; end
         if (eSelRank > 0 && imem_ready) begin
            eApply   = 1;
            ePcEn    = 1;
            ePcSel   = 2'b10;
            eTarget  = eSelAddr;
            eFlushIf = 1;
            eFlushEx = (eSelRank >= 2);
            eTrapAck = (eSelRank == 3);
         end else if (eSelRank > 0 && takeNew) begin
            eCapture = 1;
            eFlushIf = 1;
            eFlushEx = (eSelRank >= 2);
         end else if (eSelRank > 0) begin
            eFlushEx = load_use;
         end else begin
            ePcEn    = imem_ready && !load_use;
            eFlushEx = load_use;
         end
      end
   endtask

   task automatic advanceModel();
      if (mBootLeft > 0) begin
         mBootLeft--;
      end else if (eApply) begin
         mPendValid  = 1'b0;
         mShadowLeft = SHADOW_CYCLES;
      end else begin
         if (eCapture) begin
            mPendValid = 1'b1;
            mPendAddr  = eSelAddr;
            mPendRank  = eSelRank;
         end
         if (mShadowLeft > 0) mShadowLeft--;
      end
      if (eTrapAck) trapHeld = 1'b0;
   endtask

   task automatic checkOutput();
      chk("pc_en", {31'd0, pc_en}, {31'd0, ePcEn});
      chk("pc_sel", {30'd0, pc_sel}, {30'd0, ePcSel});
      chk("target", target, eTarget);
      chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, eFlushIf});
      chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, eFlushEx});
      chk("trap_ack", {31'd0, trap_ack}, {31'd0, eTrapAck});
   endtask

   task automatic evalCycle();
      #3;
      computeExpected();
      checkOutput();
   endtask

   task automatic endCycle();
      advanceModel();
      @(posedge clk);
      #1;
   endtask

   // Asserts reset mid-cycle with inputs still live; outputs must drop at once.
   task automatic doReset();
      rst = 1'b1;
      #1;
      chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
      chk("rst_pc_sel", {30'd0, pc_sel}, 32'd0);
      chk("rst_target", target, 32'd0);
      chk("rst_flush_if_id", {31'd0, flush_if_id}, 32'd0);
      chk("rst_flush_id_ex", {31'd0, flush_id_ex}, 32'd0);
      chk("rst_trap_ack", {31'd0, trap_ack}, 32'd0);
      idle();
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic randomStimulus();
      if (!trapHeld && $urandom_range(0, 15) == 0) begin
         trapHeld    = 1'b1;
         trapVecHeld = $urandom;
      end
      applyStimulus(trapHeld, trapVecHeld,
                    $urandom_range(0, 7) == 0, $urandom,
                    $urandom_range(0, 4) == 0, $urandom,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
   endtask

   initial begin
      trapVecHeld = '0;
      idle();
      modelReset();
      @(posedge clk);
      #1;
      doReset();

      for (int i = 0; i < BOOT_CYCLES; i++) begin
         evalCycle();
         pin("boot_pc_en", {31'd0, pc_en}, {31'd0, ePcEn}, 32'd0);
         endCycle();
      end
      evalCycle();
      pin("first_fetch_pc_en", {31'd0, pc_en}, {31'd0, ePcEn}, 32'd1);
      pin("first_fetch_pc_sel", {30'd0, pc_sel}, {30'd0, ePcSel}, 32'd0);
      endCycle();
      idle(); evalCycle(); endCycle();

      applyStimulus(0, 0, 1, 32'h100, 0, 0, 0, 1);
      evalCycle();
      pin("br_pc_sel", {30'd0, pc_sel}, {30'd0, ePcSel}, 32'd2);
      pin("br_target", target, eTarget, 32'h100);
      pin("br_flush_if_id", {31'd0, flush_if_id}, {31'd0, eFlushIf}, 32'd1);
      pin("br_flush_id_ex", {31'd0, flush_id_ex}, {31'd0, eFlushEx}, 32'd1);
      endCycle();
      applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 1);
      evalCycle();
      pin("shadow_jmp_pc_sel", {30'd0, pc_sel}, {30'd0, ePcSel}, 32'd0);
      endCycle();
      idle(); evalCycle(); endCycle();
      applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 1);
      evalCycle();
      pin("jmp_pc_sel", {30'd0, pc_sel}, {30'd0, ePcSel}, 32'd2);
      pin("jmp_target", target, eTarget, 32'h200);
      pin("jmp_flush_id_ex", {31'd0, flush_id_ex}, {31'd0, eFlushEx}, 32'd0);
      endCycle();
      idle(); evalCycle(); endCycle();
      idle(); evalCycle(); endCycle();

      applyStimulus(1, 32'h80, 1, 32'h500, 1, 32'h600, 0, 1);
      evalCycle();
      pin("all_target", target, eTarget, 32'h80);
      pin("all_trap_ack", {31'd0, trap_ack}, {31'd0, eTrapAck}, 32'd1);
      endCycle();
      idle();
      evalCycle();
      pin("after_trap_ack", {31'd0, trap_ack}, {31'd0, eTrapAck}, 32'd0);
      endCycle();
      idle(); evalCycle(); endCycle();

      applyStimulus(0, 0, 0, 0, 1, 32'h40, 0, 0);
      evalCycle();
      pin("cap_jmp_pc_en", {31'd0, pc_en}, {31'd0, ePcEn}, 32'd0);
      pin("cap_jmp_flush_if_id", {31'd0, flush_if_id}, {31'd0, eFlushIf}, 32'd1);
      endCycle();
      applyStimulus(0, 0, 1, 32'h60, 0, 0, 0, 0);
      evalCycle();
      pin("cap_br_flush_id_ex", {31'd0, flush_id_ex}, {31'd0, eFlushEx}, 32'd1);
      endCycle();
      idle();
      evalCycle();
      pin("pend_pc_sel", {30'd0, pc_sel}, {30'd0, ePcSel}, 32'd2);
      pin("pend_target", target, eTarget, 32'h60);
      endCycle();
      idle();
      evalCycle();
      pin("pend_once_pc_sel", {30'd0, pc_sel}, {30'd0, ePcSel}, 32'd0);
      endCycle();
      idle(); evalCycle(); endCycle();
      idle(); evalCycle(); endCycle();

      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      evalCycle();
      pin("lu_pc_en", {31'd0, pc_en}, {31'd0, ePcEn}, 32'd0);
      pin("lu_flush_id_ex", {31'd0, flush_id_ex}, {31'd0, eFlushEx}, 32'd1);
      pin("lu_flush_if_id", {31'd0, flush_if_id}, {31'd0, eFlushIf}, 32'd0);
      endCycle();

      applyStimulus(0, 0, 1, 32'h300, 0, 0, 0, 0);
      evalCycle();
      endCycle();
      idle();
      doReset();

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 599) == 0) doReset();
         randomStimulus();
         evalCycle();
         endCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
